ram_pipelined: RTL and testbench

//  Dual-port byte-addressed core memory, successor to the combinational RAM: registered reads with

---
 rtl/ram_pkg.sv | 39 +++
 rtl/ram_pipelined_if.sv | 40 ++++
 rtl/ram_rd_pipe.sv | 31 +++
 rtl/ram_pipelined.sv | 220 ++++++++++++++++++++++
 tb/tb_ram_pipelined.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the pipelined core memory: access sizes,
// port-B sequencing states, byte counts and load extension.
package ram_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } b_state_e;

    // Number of bytes touched by an access; 0 flags an illegal size code.
    function automatic logic [2:0] size_bytes(input size_e sz);
        logic [2:0] n;
        case (sz)
            SZ_B:    n = 3'd1;
            SZ_H:    n = 3'd2;
            SZ_W:    n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    // Sign/zero extend a little-endian load; words pass through untouched.
    function automatic logic [31:0] extend(input logic [31:0] w, input size_e sz, input logic uns);
        logic [31:0] r;
        case (sz)
            SZ_B:    r = uns ? {24'h000000, w[7:0]}  : {{24{w[7]}}, w[7:0]};
            SZ_H:    r = uns ? {16'h0000, w[15:0]}   : {{16{w[15]}}, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ram_pipelined_if.sv
// Bus bundle for the pipelined memory: fetch port A, load/store port B and
// the byte preload port.
interface ram_pipelined_if;
    import ram_pkg::*;

    logic        a_req;
    logic [31:0] a_addr;
    logic        a_ready;
    logic        a_rvalid;
    logic [31:0] a_rdata;
    logic        a_err;

    logic        b_req;
    logic        b_we;
    size_e       b_size;
    logic        b_unsigned;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic        b_ready;
    logic        b_rvalid;
    logic [31:0] b_rdata;
    logic        b_err;

    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [7:0]  ld_data;

    modport master (
        output a_req, a_addr, b_req, b_we, b_size, b_unsigned, b_addr, b_wdata,
               ld_valid, ld_addr, ld_data,
        input  a_ready, a_rvalid, a_rdata, a_err, b_ready, b_rvalid, b_rdata, b_err
    );

    modport slave (
        input  a_req, a_addr, b_req, b_we, b_size, b_unsigned, b_addr, b_wdata,
               ld_valid, ld_addr, ld_data,
        output a_ready, a_rvalid, a_rdata, a_err, b_ready, b_rvalid, b_rdata, b_err
    );

endinterface

// File: rtl/ram_rd_pipe.sv
// Fixed-depth response delay line; reset clears every stage so in-flight
// responses vanish.
module ram_rd_pipe #(
    parameter int DEPTH = 1,
    parameter int W     = 34
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    output logic [W-1:0] out_data
);

    logic [W-1:0] stage_r [DEPTH];

    // Shift the response word one stage per clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign out_data = stage_r[DEPTH-1];

endmodule

// File: rtl/ram_pipelined.sv
// Dual-port byte memory with registered, latency-parametrised responses.
// Port A fetches aligned words; port B does B/H/W loads and stores and splits
// an access crossing a word boundary into two beats on consecutive cycles.
module ram_pipelined
    import ram_pkg::*;
#(
    parameter int MEM_SIZE   = 4096,
    parameter int RD_LATENCY = 1
) (
    input  logic           clk,
    input  logic           rst,
    ram_pipelined_if.slave bus
);

    localparam int          AW        = $clog2(MEM_SIZE);
    localparam logic [32:0] MEM_LIMIT = 33'(MEM_SIZE);

    logic [7:0]    mem_r [MEM_SIZE];
    b_state_e      state_r, state_s;
    logic          run_r;

    // Second-beat context of a split port-B access.
    logic [AW-1:0] sp_addr_r;
    logic          sp_we_r;
    size_e         sp_size_r;
    logic          sp_uns_r;
    logic [31:0]   sp_wdata_r;
    logic [2:0]    sp_k1_r;
    logic [2:0]    sp_n_r;
    logic [31:0]   sp_rbuf_r;

    logic          a_ready_s, b_ready_s, ld_hit_s;
    logic          a_acc_s, a_err_s;
    logic [31:0]   a_word_s, a_rsp_data_s;
    logic [AW-1:0] a_base_s;
    logic [2:0]    b_n_s, b_room_s, b_k1_s;
    logic          b_err_s, b_mis_s, b_acc_s, b_go_s, split_start_s;
    logic [AW-1:0] beat_base_s;
    logic          beat_we_s;
    logic [2:0]    beat_lo_s, beat_hi_s;
    logic [31:0]   beat_wdata_s;
    logic [3:0]    lane_en_s;
    logic [AW-1:0] lane_addr_s [4];
    logic [31:0]   lane_rd_s;
    logic          b_rsp_valid_s, b_rsp_err_s;
    logic [31:0]   b_rsp_data_s;
    logic [33:0]   a_pipe_out_s, b_pipe_out_s;

    assign a_ready_s   = run_r & ~bus.ld_valid;
    assign b_ready_s   = run_r & ~bus.ld_valid & (state_r == ST_IDLE);
    assign ld_hit_s    = bus.ld_valid & ({1'b0, bus.ld_addr} < MEM_LIMIT);
    assign a_base_s    = bus.a_addr[AW-1:0];
    assign bus.a_ready = a_ready_s;
    assign bus.b_ready = b_ready_s;

    // Port A: range/alignment check and word read (reads see pre-edge contents).
    always_comb begin
        a_acc_s  = bus.a_req & a_ready_s;
        a_err_s  = (({1'b0, bus.a_addr} + 33'd4) > MEM_LIMIT) | (bus.a_addr[1:0] != 2'b00);
        a_word_s = 32'h0;
        for (int i = 0; i < 4; i++) begin
            a_word_s[8*i +: 8] = mem_r[a_base_s + AW'(i)];
        end
        if (a_acc_s & ~a_err_s) begin
            a_rsp_data_s = a_word_s;
        end else begin
            a_rsp_data_s = 32'h0;
        end
    end

    // Port B request decode: size, 33-bit range check, misalignment, beat-1 length.
    always_comb begin
        b_n_s    = size_bytes(bus.b_size);
        b_err_s  = (b_n_s == 3'd0) | (({1'b0, bus.b_addr} + {30'd0, b_n_s}) > MEM_LIMIT);
        b_mis_s  = ((b_n_s == 3'd2) & bus.b_addr[0]) |
                   ((b_n_s == 3'd4) & (bus.b_addr[1:0] != 2'b00));
        b_room_s = 3'd4 - {1'b0, bus.b_addr[1:0]};
        if (b_room_s < b_n_s) begin
            b_k1_s = b_room_s;
        end else begin
            b_k1_s = b_n_s;
        end
        b_acc_s       = bus.b_req & b_ready_s;
        b_go_s        = b_acc_s & ~b_err_s;
        split_start_s = b_go_s & b_mis_s;
    end

    // Select which access bytes (lanes lo..hi-1) this edge touches, and read them.
    always_comb begin
        beat_base_s  = '0;
        beat_we_s    = 1'b0;
        beat_lo_s    = 3'd0;
        beat_hi_s    = 3'd0;
        beat_wdata_s = 32'h0;
        if (state_r == ST_SPLIT) begin
            beat_base_s  = sp_addr_r;
            beat_we_s    = sp_we_r;
            beat_lo_s    = sp_k1_r;
            beat_hi_s    = sp_n_r;
            beat_wdata_s = sp_wdata_r;
        end else if (b_go_s) begin
            beat_base_s  = bus.b_addr[AW-1:0];
            beat_we_s    = bus.b_we;
            beat_hi_s    = b_k1_s;
            beat_wdata_s = bus.b_wdata;
        end else begin
            beat_hi_s    = 3'd0;
        end
        lane_rd_s = 32'h0;
        for (int i = 0; i < 4; i++) begin
            lane_en_s[i]   = (3'(i) >= beat_lo_s) & (3'(i) < beat_hi_s);
            lane_addr_s[i] = beat_base_s + AW'(i);
            if (lane_en_s[i]) begin
                lane_rd_s[8*i +: 8] = mem_r[lane_addr_s[i]];
            end else begin
                lane_rd_s[8*i +: 8] = 8'h00;
            end
        end
    end

    // Port B response: single-beat and error responses at accept, split ones after beat 2.
    always_comb begin
        b_rsp_valid_s = 1'b0;
        b_rsp_err_s   = 1'b0;
        b_rsp_data_s  = 32'h0;
        if (state_r == ST_SPLIT) begin
            b_rsp_valid_s = 1'b1;
            if (sp_we_r) begin
                b_rsp_data_s = 32'h0;
            end else begin
                b_rsp_data_s = extend(sp_rbuf_r | lane_rd_s, sp_size_r, sp_uns_r);
            end
        end else if (b_acc_s & ~split_start_s) begin
            b_rsp_valid_s = 1'b1;
            b_rsp_err_s   = b_err_s;
            if (b_err_s | bus.b_we) begin
                b_rsp_data_s = 32'h0;
            end else begin
                b_rsp_data_s = extend(lane_rd_s, bus.b_size, bus.b_unsigned);
            end
        end else begin
            b_rsp_valid_s = 1'b0;
        end
    end

    // Split FSM next state: a misaligned legal access spends one cycle in SPLIT.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (split_start_s) begin
                    state_s = ST_SPLIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SPLIT: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Control state and the captured context of a split access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            run_r      <= 1'b0;
            sp_addr_r  <= '0;
            sp_we_r    <= 1'b0;
            sp_size_r  <= SZ_B;
            sp_uns_r   <= 1'b0;
            sp_wdata_r <= 32'h0;
            sp_k1_r    <= 3'd0;
            sp_n_r     <= 3'd0;
            sp_rbuf_r  <= 32'h0;
        end else begin
            state_r <= state_s;
            run_r   <= 1'b1;
            if (split_start_s) begin
                sp_addr_r  <= bus.b_addr[AW-1:0];
                sp_we_r    <= bus.b_we;
                sp_size_r  <= bus.b_size;
                sp_uns_r   <= bus.b_unsigned;
                sp_wdata_r <= bus.b_wdata;
                sp_k1_r    <= b_k1_s;
                sp_n_r     <= b_n_s;
                sp_rbuf_r  <= lane_rd_s;
            end
        end
    end

    // Byte writes: store lanes first, preload last so it wins on a shared byte.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_en_s[i] & beat_we_s) begin
                mem_r[lane_addr_s[i]] <= beat_wdata_s[8*i +: 8];
            end
        end
        if (ld_hit_s) begin
            mem_r[bus.ld_addr[AW-1:0]] <= bus.ld_data;
        end
    end

    ram_rd_pipe #(.DEPTH(RD_LATENCY), .W(34)) u_a_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_data  ({a_acc_s, a_acc_s & a_err_s, a_rsp_data_s}),
        .out_data (a_pipe_out_s)
    );

    ram_rd_pipe #(.DEPTH(RD_LATENCY), .W(34)) u_b_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_data  ({b_rsp_valid_s, b_rsp_err_s, b_rsp_data_s}),
        .out_data (b_pipe_out_s)
    );

    assign {bus.a_rvalid, bus.a_err, bus.a_rdata} = a_pipe_out_s;
    assign {bus.b_rvalid, bus.b_err, bus.b_rdata} = b_pipe_out_s;

endmodule

// File: tb/tb_ram_pipelined.sv
// Self-checking bench for ram_pipelined: directed scenarios followed by random
// traffic, all compared against a byte-array reference model with response
// queues keyed by the clock edge on which each response must appear.
module tb_ram_pipelined;
    import ram_pkg::*;

    localparam int MS  = 4096;
    localparam int LAT = 2;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ram_pipelined_if bus();

    ram_pipelined #(.MEM_SIZE(MS), .RD_LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  ref_mem [MS];
    rsp_t        qa[$];
    rsp_t        qb[$];
    int          checks = 0;
    int          passes = 0;
    int          edge_n = 0;
    bit          running = 1'b0;
    bit          split_pend = 1'b0;
    int          sp_addr, sp_n, sp_k1;
    bit          sp_we, sp_uns;
    logic [31:0] sp_wdata;
    longint      sp_val;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] ext(longint v, int n, bit uns);
        longint half;
        if (n == 4 || uns) return 32'(v);
        half = longint'(1) << (8 * n - 1);
        if (v >= half) return 32'(v - 2 * half);
        return 32'(v);
    endfunction

    // Apply access bytes lo..hi-1 of the current port-B operation to the model.
    task automatic do_bytes(int lo, int hi);
        for (int i = lo; i < hi; i++) begin
            if (sp_we) ref_mem[sp_addr + i] = sp_wdata[8*i +: 8];
            else sp_val = sp_val | (longint'(ref_mem[sp_addr + i]) << (8 * i));
        end
    endtask

    task automatic model_a(int e);
        longint ad;
        rsp_t r;
        ad = longint'(bus.a_addr);
        r.due = e + LAT - 1; r.err = 1'b0; r.data = 32'h0;
        if (ad + 4 > MS || ad % 4 != 0) r.err = 1'b1;
        else for (int i = 0; i < 4; i++) r.data[8*i +: 8] = ref_mem[int'(ad) + i];
        qa.push_back(r);
    endtask

    task automatic model_b_start(int e);
        longint ad;
        int n, k1;
        rsp_t r;
        ad = longint'(bus.b_addr);
        case (int'(bus.b_size))
            0: n = 1;
            1: n = 2;
            2: n = 4;
            default: n = 0;
        endcase
        r.due = e + LAT - 1; r.err = 1'b0; r.data = 32'h0;
        if (n == 0 || ad + n > MS) begin
            r.err = 1'b1;
            qb.push_back(r);
        end else begin
            sp_addr = int'(ad); sp_n = n; sp_we = bus.b_we; sp_uns = bus.b_unsigned;
            sp_wdata = bus.b_wdata; sp_val = 0;
            if (ad % n == 0) k1 = n;
            else k1 = (4 - int'(ad % 4) < n) ? 4 - int'(ad % 4) : n;
            do_bytes(0, k1);
            if (ad % n == 0) begin
                r.data = sp_we ? 32'h0 : ext(sp_val, n, sp_uns);
                qb.push_back(r);
            end else begin
                split_pend = 1'b1;
                sp_k1 = k1;
            end
        end
    endtask

    task automatic model_b_beat2(int e);
        rsp_t r;
        do_bytes(sp_k1, sp_n);
        r.due = e + LAT - 1; r.err = 1'b0;
        r.data = sp_we ? 32'h0 : ext(sp_val, sp_n, sp_uns);
        qb.push_back(r);
        split_pend = 1'b0;
    endtask

    // One clock: check readies, update the model for this edge, then check responses.
    task automatic step();
        bit a_rdy, b_rdy, ev;
        int e;
        rsp_t r;
        #1;
        a_rdy = running && !bus.ld_valid;
        b_rdy = a_rdy && !split_pend;
        chk("a_ready", 32'(bus.a_ready), 32'(a_rdy));
        chk("b_ready", 32'(bus.b_ready), 32'(b_rdy));
        e = edge_n + 1;
        if (bus.a_req && a_rdy) model_a(e);
        if (split_pend) model_b_beat2(e);
        else if (bus.b_req && b_rdy) model_b_start(e);
        if (bus.ld_valid && longint'(bus.ld_addr) < MS) ref_mem[int'(bus.ld_addr)] = bus.ld_data;
        @(posedge clk);
        edge_n++;
        running = !rst;
        @(negedge clk);
        ev = (qa.size() > 0) && (qa[0].due == edge_n);
        chk("a_rvalid", 32'(bus.a_rvalid), 32'(ev));
        if (ev) begin
            r = qa.pop_front();
            chk("a_err", 32'(bus.a_err), 32'(r.err));
            chk("a_rdata", bus.a_rdata, r.data);
        end
        ev = (qb.size() > 0) && (qb[0].due == edge_n);
        chk("b_rvalid", 32'(bus.b_rvalid), 32'(ev));
        if (ev) begin
            r = qb.pop_front();
            chk("b_err", 32'(bus.b_err), 32'(r.err));
            chk("b_rdata", bus.b_rdata, r.data);
        end
    endtask

    task automatic run_idle(int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic idle_in();
        bus.a_req = 1'b0; bus.a_addr = 32'h0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_size = SZ_B; bus.b_unsigned = 1'b0;
        bus.b_addr = 32'h0; bus.b_wdata = 32'h0;
        bus.ld_valid = 1'b0; bus.ld_addr = 32'h0; bus.ld_data = 8'h00;
    endtask

    task automatic ld(int ad, logic [7:0] d);
        bus.ld_valid = 1'b1; bus.ld_addr = 32'(ad); bus.ld_data = d;
        step();
        bus.ld_valid = 1'b0;
    endtask

    task automatic fetch(int ad);
        bus.a_req = 1'b1; bus.a_addr = 32'(ad);
        step();
        bus.a_req = 1'b0;
    endtask

    task automatic bop(bit we, int sz, bit uns, int ad, logic [31:0] wd);
        bus.b_req = 1'b1; bus.b_we = we; bus.b_size = size_e'(sz); bus.b_unsigned = uns;
        bus.b_addr = 32'(ad); bus.b_wdata = wd;
        step();
        bus.b_req = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        running = 1'b0;
        split_pend = 1'b0;
        qa.delete();
        qb.delete();
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return 32'hFFFF_FFFE;
        if (r < 4) return 32'(MS - 8 + $urandom_range(0, 7));
        return 32'($urandom_range(0, 63));
    endfunction

    initial begin
        idle_in();
        // Reset state
        run_idle(3);
        chk("rst_a_rdata", bus.a_rdata, 32'h0);
        chk("rst_b_rdata", bus.b_rdata, 32'h0);
        chk("rst_errs", {30'h0, bus.a_err, bus.b_err}, 32'h0);
        rst = 1'b0;
        step();
        // Fill the whole memory so the model and the array agree everywhere
        for (int i = 0; i < MS; i++) ld(i, 8'($urandom));

        // 1: preload and fetch
        ld(0, 8'h11); ld(1, 8'h22); ld(2, 8'h33); ld(3, 8'h44);
        fetch(0); run_idle(LAT - 1);
        chk("t1_fetch", bus.a_rdata, 32'h44332211);
        run_idle(1);

        // 2: signed / unsigned byte load
        ld(3, 8'h80);
        bop(1'b0, 0, 1'b0, 3, 32'h0); run_idle(LAT - 1);
        chk("t2_signed", bus.b_rdata, 32'hFFFFFF80);
        bop(1'b0, 0, 1'b1, 3, 32'h0); run_idle(LAT - 1);
        chk("t2_unsigned", bus.b_rdata, 32'h00000080);
        run_idle(1);

        // 3: misaligned word store, ack after the extra split cycle
        bop(1'b1, 2, 1'b0, 6, 32'hDEADBEEF);
        #1 chk("t3_busy", 32'(bus.b_ready), 32'd0);
        run_idle(LAT + 1);
        fetch(4); run_idle(LAT - 1);
        chk("t3_w4_hi", {16'h0, bus.a_rdata[31:16]}, 32'h0000BEEF);
        fetch(8); run_idle(LAT - 1);
        chk("t3_w8_lo", {16'h0, bus.a_rdata[15:0]}, 32'h0000DEAD);
        bop(1'b0, 2, 1'b0, 4, 32'h0);
        bop(1'b0, 2, 1'b0, 8, 32'h0);
        run_idle(LAT);

        // 4: out-of-range halfword load, misaligned fetch
        bop(1'b0, 1, 1'b0, MS - 1, 32'h0); run_idle(LAT - 1);
        chk("t4_b_err", {31'h0, bus.b_err}, 32'h1);
        chk("t4_b_rdata", bus.b_rdata, 32'h0);
        fetch(2); run_idle(LAT - 1);
        chk("t4_a_err", {31'h0, bus.a_err}, 32'h1);
        bop(1'b0, 0, 1'b1, MS - 1, 32'h0);
        run_idle(LAT);

        // 5: same-cycle fetch and store to one word returns the old value
        for (int i = 0; i < 4; i++) ld(16 + i, 8'h00);
        bus.a_req = 1'b1; bus.a_addr = 32'h10;
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_size = SZ_W; bus.b_addr = 32'h10;
        bus.b_wdata = 32'h5;
        step();
        idle_in();
        run_idle(LAT - 1);
        chk("t5_old", bus.a_rdata, 32'h0);
        run_idle(1);
        fetch(16); run_idle(LAT - 1);
        chk("t5_new", bus.a_rdata, 32'h5);
        run_idle(1);

        // 6: reset in the middle of a split store
        bop(1'b1, 2, 1'b0, 6, 32'hCAFEF00D);
        apply_reset();
        run_idle(2);
        rst = 1'b0;
        step();
        fetch(4); run_idle(LAT - 1);
        chk("t6_b67", {16'h0, bus.a_rdata[31:16]}, 32'h0000F00D);
        fetch(8); run_idle(LAT - 1);
        chk("t6_b89", {16'h0, bus.a_rdata[15:0]}, 32'h0000DEAD);
        run_idle(1);

        // Random mixed traffic
        for (int n = 0; n < 3000; n++) begin
            bus.ld_valid   = ($urandom_range(0, 15) == 0);
            bus.ld_addr    = rand_addr();
            bus.ld_data    = 8'($urandom);
            bus.a_req      = 1'($urandom_range(0, 1));
            bus.a_addr     = ($urandom_range(0, 7) == 0) ? rand_addr() : (rand_addr() & 32'hFFFF_FFFC);
            bus.b_req      = 1'($urandom_range(0, 1));
            bus.b_we       = 1'($urandom_range(0, 1));
            bus.b_size     = size_e'($urandom_range(0, 3));
            bus.b_unsigned = 1'($urandom_range(0, 1));
            bus.b_addr     = rand_addr();
            bus.b_wdata    = $urandom;
            step();
        end
        idle_in();
        run_idle(LAT + 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
